// File: rtl/my_io_ctrl.sv
// my_io_ctrl: memory-mapped I/O controller for the data-memory port.
// Hex digit registers out; synchronised, debounced inputs with sticky events and irq in.
//
// Ports:
//   dmem_clk        clock, all state changes on the rising edge
//   reset           synchronous active-high reset
//   addr            word address within the I/O window
//   datain          write data
//   write_io_enable write strobe
//   io_in           asynchronous switch/key inputs
//   io_out          packed digit registers, digit k at [k*DIGIT_W +: DIGIT_W]
//   dataout         registered read data
//   irq             registered |(evt & mask)
module my_io_ctrl #(
   parameter int N_DIGITS  = 6,
   parameter int DIGIT_W   = 4,
   parameter int IN_W      = 10,
   parameter int DB_CYCLES = 16
) (
   input  logic                         dmem_clk,
   input  logic                         reset,
   input  logic [4:0]                   addr,
   input  logic [31:0]                  datain,
   input  logic                         write_io_enable,
   input  logic [IN_W-1:0]              io_in,
   output logic [N_DIGITS*DIGIT_W-1:0]  io_out,
   output logic [31:0]                  dataout,
   output logic                         irq
);

   localparam int CNT_W = $clog2(DB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

   localparam logic [4:0] A_CLR  = 5'h08;
   localparam logic [4:0] A_DB   = 5'h10;
   localparam logic [4:0] A_EVT  = 5'h11;
   localparam logic [4:0] A_RAW  = 5'h12;
   localparam logic [4:0] A_MASK = 5'h13;

   logic [DIGIT_W-1:0] digit_q [N_DIGITS];
   logic [DIGIT_W-1:0] digit_d [N_DIGITS];
   logic [IN_W-1:0]    sync1_q;
   logic [IN_W-1:0]    sync2_q;
   logic [IN_W-1:0]    db_q;
   logic [IN_W-1:0]    db_d;
   logic [CNT_W-1:0]   cnt_q [IN_W];
   logic [CNT_W-1:0]   cnt_d [IN_W];
   logic [IN_W-1:0]    evt_q;
   logic [IN_W-1:0]    evt_d;
   logic [IN_W-1:0]    mask_q;
   logic [IN_W-1:0]    mask_d;
   logic [IN_W-1:0]    w1c;
   logic [31:0]        dout_q;
   logic [31:0]        dout_d;
   logic               irq_q;
   logic               irq_d;
   logic               unused_datain;

   // Upper write-data bits are only meaningful for some registers.
   assign unused_datain = ^datain;

   // Per-bit debouncer: a mismatch must persist for DB_CYCLES samples.
   always_comb begin
      db_d = db_q;
      for (int i = 0; i < IN_W; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               db_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Writes: digits, clear-all, W1C events, mask.
   always_comb begin
      for (int k = 0; k < N_DIGITS; k++) begin
         digit_d[k] = digit_q[k];
      end
      w1c    = '0;
      mask_d = mask_q;
      if (write_io_enable) begin
         for (int k = 0; k < N_DIGITS; k++) begin
            if (addr == 5'(k)) begin
               digit_d[k] = datain[DIGIT_W-1:0];
            end
         end
         if (addr == A_CLR) begin
            for (int k = 0; k < N_DIGITS; k++) begin
               digit_d[k] = '0;
            end
         end
         if (addr == A_EVT) begin
            w1c = datain[IN_W-1:0];
         end
         if (addr == A_MASK) begin
            mask_d = datain[IN_W-1:0];
         end
      end
   end

   // A rising debounced level wins over a simultaneous clear.
   always_comb begin
      evt_d = (evt_q & ~w1c) | (db_d & ~db_q);
      irq_d = |(evt_d & mask_q);
   end

   // Read mux samples pre-write state, so read-modify in one cycle
   // returns the old value.
   always_comb begin
      dout_d = '0;
      if (addr[4:3] == 2'b00) begin
         for (int k = 0; k < N_DIGITS; k++) begin
            if (addr[2:0] == 3'(k)) begin
               dout_d[DIGIT_W-1:0] = digit_q[k];
            end
         end
      end else begin
         case (addr)
            A_DB:    dout_d[IN_W-1:0] = db_q;
            A_EVT:   dout_d[IN_W-1:0] = evt_q;
            A_RAW:   dout_d[IN_W-1:0] = sync2_q;
            A_MASK:  dout_d[IN_W-1:0] = mask_q;
            default: dout_d = '0;
         endcase
      end
   end

   always_ff @(posedge dmem_clk) begin
      if (reset) begin
         for (int k = 0; k < N_DIGITS; k++) begin
            digit_q[k] <= '0;
         end
         for (int i = 0; i < IN_W; i++) begin
            cnt_q[i] <= '0;
         end
         sync1_q <= '0;
         sync2_q <= '0;
         db_q    <= '0;
         evt_q   <= '0;
         mask_q  <= '0;
         dout_q  <= '0;
         irq_q   <= 1'b0;
      end else begin
         for (int k = 0; k < N_DIGITS; k++) begin
            digit_q[k] <= digit_d[k];
         end
         for (int i = 0; i < IN_W; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         sync1_q <= io_in;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         evt_q   <= evt_d;
         mask_q  <= mask_d;
         dout_q  <= dout_d;
         irq_q   <= irq_d;
      end
   end

   for (genvar k = 0; k < N_DIGITS; k++) begin : g_out
      assign io_out[k*DIGIT_W +: DIGIT_W] = digit_q[k];
   end

   assign dataout = dout_q;
   assign irq     = irq_q;

endmodule
